// File: rtl/vmem_arbiter_pkg.sv
// Shared types and default widths for the vector data-RAM arbiter.
// Owner encoding selects which requester drives the RAM port in an issue cycle.
package vmem_arbiter_pkg;

    localparam int VM_ADDR_W   = 14;
    localparam int VM_DATA_W   = 256;
    localparam int VM_BE_W     = VM_DATA_W / 8;
    localparam int VM_RD_LAT   = 2;
    localparam int VM_MAX_WAIT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        P_RD = 2'd1,
        H_RD = 2'd2
    } state_t;

    typedef enum logic {
        OWN_P = 1'b0,
        OWN_H = 1'b1
    } owner_t;

endpackage

// File: rtl/arb_wait_counter.sv
// Saturating host-starvation counter: counts cycles the host waits, clears on grant.
// No latency on sat_o beyond the count register; no backpressure of its own.
module arb_wait_counter #(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc_i,
    input  logic clr_i,
    output logic sat_o
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign sat_o = (cnt_q == CW'(MAX_WAIT));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !sat_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/vmem_arbiter.sv
// Arbitrates the data block RAM between the processor and the host loader; writes issue
// and complete in one cycle, reads return RD_LAT cycles later while p_stall freezes the pipe.
module vmem_arbiter
    import vmem_arbiter_pkg::*;
#(
    parameter int ADDR_W   = VM_ADDR_W,
    parameter int DATA_W   = VM_DATA_W,
    parameter int BE_W     = VM_BE_W,
    parameter int RD_LAT   = VM_RD_LAT,
    parameter int MAX_WAIT = VM_MAX_WAIT
) (
    input  logic              clk,
    input  logic              reset,

    input  logic [ADDR_W-1:0] p_address,
    input  logic [BE_W-1:0]   p_byteena,
    input  logic [DATA_W-1:0] p_writedata,
    input  logic              p_rden,
    input  logic              p_wren,
    output logic [DATA_W-1:0] p_readdata,
    output logic              p_stall,

    input  logic              h_req,
    input  logic              h_we,
    input  logic [ADDR_W-1:0] h_address,
    input  logic [BE_W-1:0]   h_byteena,
    input  logic [DATA_W-1:0] h_writedata,
    output logic              h_gnt,
    output logic              h_rvalid,
    output logic [DATA_W-1:0] h_readdata,

    output logic [ADDR_W-1:0] ram_address,
    output logic [BE_W-1:0]   ram_byteena,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_rden,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q
);

    localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    state_t            state_q, state_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic [DATA_W-1:0] p_rdata_q, h_rdata_q;

    logic   p_req;
    logic   idle;
    logic   wsat;
    logic   host_win;
    logic   proc_win;
    logic   issue;
    logic   issue_wr;
    logic   p_done;
    logic   h_done;
    owner_t own;

    assign p_req = p_rden | p_wren;

    // Combinational outputs are qualified with reset so everything reads 0 while it is held.
    assign idle     = reset && (state_q == IDLE);
    assign host_win = idle && h_req && (wsat || !p_req);
    assign proc_win = idle && !host_win && p_req;
    assign issue    = host_win || proc_win;
    assign own      = host_win ? OWN_H : OWN_P;
    assign issue_wr = (own == OWN_H) ? h_we : p_wren;

    assign p_done = reset && (state_q == P_RD) && (lat_q == '0);
    assign h_done = reset && (state_q == H_RD) && (lat_q == '0);

    arb_wait_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_counter (
        .clk   (clk),
        .reset (reset),
        .inc_i (h_req && !host_win),
        .clr_i (host_win),
        .sat_o (wsat)
    );

    always_comb begin
        ram_address = '0;
        ram_byteena = '0;
        ram_data    = '0;
        ram_rden    = 1'b0;
        ram_wren    = 1'b0;
        if (issue) begin
            if (own == OWN_H) begin
                ram_address = h_address;
                ram_byteena = h_byteena;
                ram_data    = h_writedata;
            end else begin
                ram_address = p_address;
                ram_byteena = p_byteena;
                ram_data    = p_writedata;
            end
            ram_wren = issue_wr;
            ram_rden = !issue_wr;
        end
    end

    // A processor write finishes in its issue cycle; a read finishes on the data-return cycle.
    assign p_stall    = reset && p_req && !((proc_win && p_wren) || p_done);
    assign h_gnt      = host_win;
    assign h_rvalid   = h_done;
    assign p_readdata = p_done ? ram_q : p_rdata_q;
    assign h_readdata = h_done ? ram_q : h_rdata_q;

    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        unique case (state_q)
            IDLE: begin
                if (issue && !issue_wr) begin
                    lat_d   = LAT_W'(RD_LAT - 1);
                    state_d = (own == OWN_H) ? H_RD : P_RD;
                end
            end
            P_RD, H_RD: begin
                if (lat_q == '0) begin
                    state_d = IDLE;
                end else begin
                    lat_d = lat_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                lat_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            lat_q     <= '0;
            p_rdata_q <= '0;
            h_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            if (p_done) begin
                p_rdata_q <= ram_q;
            end
            if (h_done) begin
                h_rdata_q <= ram_q;
            end
        end
    end

endmodule

// File: tb/tb_vmem_arbiter.sv
// Directed bench for vmem_arbiter: inputs change 1ns after the rising edge,
// outputs are checked on the falling edge of the same cycle.
module tb_vmem_arbiter;

    localparam int AW = 14;
    localparam int DW = 256;
    localparam int BW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] p_address;
    logic [BW-1:0] p_byteena;
    logic [DW-1:0] p_writedata;
    logic          p_rden;
    logic          p_wren;
    logic [DW-1:0] p_readdata;
    logic          p_stall;
    logic          h_req;
    logic          h_we;
    logic [AW-1:0] h_address;
    logic [BW-1:0] h_byteena;
    logic [DW-1:0] h_writedata;
    logic          h_gnt;
    logic          h_rvalid;
    logic [DW-1:0] h_readdata;
    logic [AW-1:0] ram_address;
    logic [BW-1:0] ram_byteena;
    logic [DW-1:0] ram_data;
    logic          ram_rden;
    logic          ram_wren;
    logic [DW-1:0] ram_q;

    int total = 0;
    int bad   = 0;

    localparam logic [DW-1:0] PAT_A5 = {32{8'hA5}};
    localparam logic [DW-1:0] PAT_5A = {32{8'h5A}};
    localparam logic [DW-1:0] PAT_C3 = {32{8'hC3}};
    localparam logic [DW-1:0] PAT_3C = {32{8'h3C}};
    localparam logic [DW-1:0] JUNK   = {8{32'hDEADBEEF}};
    localparam logic [DW-1:0] WDAT   = {8{32'h01234567}};
    localparam logic [DW-1:0] HDAT   = {8{32'h89ABCDEF}};

    always #5 clk = ~clk;

    vmem_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .p_address   (p_address),
        .p_byteena   (p_byteena),
        .p_writedata (p_writedata),
        .p_rden      (p_rden),
        .p_wren      (p_wren),
        .p_readdata  (p_readdata),
        .p_stall     (p_stall),
        .h_req       (h_req),
        .h_we        (h_we),
        .h_address   (h_address),
        .h_byteena   (h_byteena),
        .h_writedata (h_writedata),
        .h_gnt       (h_gnt),
        .h_rvalid    (h_rvalid),
        .h_readdata  (h_readdata),
        .ram_address (ram_address),
        .ram_byteena (ram_byteena),
        .ram_data    (ram_data),
        .ram_rden    (ram_rden),
        .ram_wren    (ram_wren),
        .ram_q       (ram_q)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        reset       = 1'b0;
        p_address   = '0;
        p_byteena   = '0;
        p_writedata = '0;
        p_rden      = 1'b0;
        p_wren      = 1'b1;
        h_req       = 1'b1;
        h_we        = 1'b1;
        h_address   = 14'h0001;
        h_byteena   = '1;
        h_writedata = HDAT;
        ram_q       = JUNK;

        // Held in reset with live requests: every output must stay 0.
        sample();
        chk("rst_ram_wren", ram_wren, 0);
        chk("rst_ram_rden", ram_rden, 0);
        chk("rst_ram_addr", ram_address, 0);
        chk("rst_p_stall", p_stall, 0);
        chk("rst_h_gnt", h_gnt, 0);
        chk("rst_h_rvalid", h_rvalid, 0);
        chk("rst_p_readdata", p_readdata, 0);
        chk("rst_h_readdata", h_readdata, 0);

        next_cycle();
        p_wren = 1'b0;
        h_req  = 1'b0;
        h_we   = 1'b0;
        next_cycle();
        reset = 1'b1;

        // Processor write: issues and completes in one cycle.
        next_cycle();
        p_wren      = 1'b1;
        p_address   = 14'h0010;
        p_byteena   = '1;
        p_writedata = WDAT;
        sample();
        chk("pw_ram_wren", ram_wren, 1);
        chk("pw_ram_rden", ram_rden, 0);
        chk("pw_ram_addr", ram_address, 14'h0010);
        chk("pw_ram_be", ram_byteena, 32'hFFFF_FFFF);
        chk("pw_ram_data", ram_data, WDAT);
        chk("pw_p_stall", p_stall, 0);
        next_cycle();
        p_wren = 1'b0;
        sample();
        chk("pw_idle_wren", ram_wren, 0);
        chk("pw_idle_addr", ram_address, 0);
        chk("pw_idle_data", ram_data, 0);

        // Processor read, data returns two cycles after issue.
        next_cycle();
        p_rden    = 1'b1;
        p_address = 14'h0123;
        sample();
        chk("pr0_ram_rden", ram_rden, 1);
        chk("pr0_ram_addr", ram_address, 14'h0123);
        chk("pr0_p_stall", p_stall, 1);
        next_cycle();
        sample();
        chk("pr1_ram_rden", ram_rden, 0);
        chk("pr1_p_stall", p_stall, 1);
        next_cycle();
        ram_q = PAT_A5;
        sample();
        chk("pr2_ram_rden", ram_rden, 0);
        chk("pr2_p_stall", p_stall, 0);
        chk("pr2_p_readdata", p_readdata, PAT_A5);
        next_cycle();
        p_rden = 1'b0;
        ram_q  = JUNK;
        sample();
        chk("pr3_p_readdata_hold", p_readdata, PAT_A5);
        chk("pr3_ram_rden", ram_rden, 0);
        chk("pr3_p_stall", p_stall, 0);

        // Host read at the top address while the processor is idle.
        next_cycle();
        h_req     = 1'b1;
        h_we      = 1'b0;
        h_address = 14'h3FFF;
        sample();
        chk("hr0_h_gnt", h_gnt, 1);
        chk("hr0_ram_rden", ram_rden, 1);
        chk("hr0_ram_addr", ram_address, 14'h3FFF);
        chk("hr0_h_rvalid", h_rvalid, 0);
        next_cycle();
        h_req = 1'b0;
        sample();
        chk("hr1_h_gnt", h_gnt, 0);
        chk("hr1_h_rvalid", h_rvalid, 0);
        chk("hr1_ram_rden", ram_rden, 0);
        next_cycle();
        ram_q = PAT_5A;
        sample();
        chk("hr2_h_rvalid", h_rvalid, 1);
        chk("hr2_h_readdata", h_readdata, PAT_5A);
        next_cycle();
        ram_q = JUNK;
        sample();
        chk("hr3_h_rvalid", h_rvalid, 0);
        chk("hr3_h_readdata_hold", h_readdata, PAT_5A);
        chk("hr3_p_readdata_kept", p_readdata, PAT_A5);

        // Starvation: back-to-back processor writes against a held host write.
        h_we        = 1'b1;
        h_address   = 14'h0200;
        h_writedata = HDAT;
        p_address   = 14'h0100;
        p_writedata = WDAT;
        for (int c = 0; c <= 10; c++) begin
            next_cycle();
            p_wren = 1'b1;
            h_req  = (c <= 4);
            sample();
            chk($sformatf("sv%0d_h_gnt", c), h_gnt, (c == 4));
            chk($sformatf("sv%0d_p_stall", c), p_stall, (c == 4));
            chk($sformatf("sv%0d_ram_wren", c), ram_wren, 1);
            chk($sformatf("sv%0d_ram_addr", c), ram_address, (c == 4) ? 14'h0200 : 14'h0100);
            chk($sformatf("sv%0d_ram_data", c), ram_data, (c == 4) ? HDAT : WDAT);
        end
        next_cycle();
        p_wren = 1'b0;
        h_req  = 1'b0;

        // Simultaneous processor read and host read with an empty wait count.
        next_cycle();
        p_rden    = 1'b1;
        p_address = 14'h0042;
        h_req     = 1'b1;
        h_we      = 1'b0;
        h_address = 14'h0777;
        sample();
        chk("sim0_ram_addr", ram_address, 14'h0042);
        chk("sim0_h_gnt", h_gnt, 0);
        chk("sim0_p_stall", p_stall, 1);
        next_cycle();
        sample();
        chk("sim1_h_gnt", h_gnt, 0);
        chk("sim1_ram_rden", ram_rden, 0);
        next_cycle();
        ram_q = PAT_C3;
        sample();
        chk("sim2_h_gnt", h_gnt, 0);
        chk("sim2_p_stall", p_stall, 0);
        chk("sim2_p_readdata", p_readdata, PAT_C3);
        next_cycle();
        p_rden = 1'b0;
        ram_q  = JUNK;
        sample();
        chk("sim3_h_gnt", h_gnt, 1);
        chk("sim3_ram_rden", ram_rden, 1);
        chk("sim3_ram_addr", ram_address, 14'h0777);

        // Reset lands while the host read is outstanding.
        next_cycle();
        h_req = 1'b0;
        reset = 1'b0;
        sample();
        chk("rh0_h_rvalid", h_rvalid, 0);
        chk("rh0_p_readdata", p_readdata, 0);
        chk("rh0_h_readdata", h_readdata, 0);
        chk("rh0_ram_rden", ram_rden, 0);
        next_cycle();
        ram_q = PAT_5A;
        sample();
        chk("rh1_h_rvalid", h_rvalid, 0);
        chk("rh1_h_readdata", h_readdata, 0);
        next_cycle();
        reset     = 1'b1;
        ram_q     = JUNK;
        p_rden    = 1'b1;
        p_address = 14'h0055;
        sample();
        chk("rp0_h_rvalid", h_rvalid, 0);
        chk("rp0_ram_rden", ram_rden, 1);
        chk("rp0_ram_addr", ram_address, 14'h0055);
        chk("rp0_p_stall", p_stall, 1);
        next_cycle();
        sample();
        chk("rp1_p_stall", p_stall, 1);
        chk("rp1_h_rvalid", h_rvalid, 0);
        next_cycle();
        ram_q = PAT_3C;
        sample();
        chk("rp2_p_stall", p_stall, 0);
        chk("rp2_p_readdata", p_readdata, PAT_3C);
        chk("rp2_h_rvalid", h_rvalid, 0);
        next_cycle();
        p_rden = 1'b0;
        ram_q  = JUNK;
        sample();
        chk("rp3_p_readdata_hold", p_readdata, PAT_3C);
        chk("rp3_p_stall", p_stall, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vmem_arbiter.md
Name: vmem_arbiter

Overview:
- Sits directly downstream of the processor datapath's RAM port, which is driven by the vector load/store unit, and in front of the 256-bit data block RAM.
- Arbitrates RAM access between the processor and a host loader port (image load/readback over the debug link).
- Tracks the RAM read latency and returns read data to the correct requester.
- Gives the processor a stall so the pipeline freezes while a request is pending or has lost arbitration.

Parameters:
- ADDR_W, 14, word address width.
- DATA_W, 256, data width.
- BE_W, 32, byte-enable width (DATA_W/8).
- RD_LAT, 2, RAM cycles from issue to valid ram_q (≥1).
- MAX_WAIT, 4, host wait cycles before the host overrides processor priority.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- p_address  in  ADDR_W  processor address
- p_byteena  in  BE_W  processor byte enables
- p_writedata  in  DATA_W  processor write data
- p_rden  in  1  processor read request (level, held until complete)
- p_wren  in  1  processor write request (level, held until complete)
- p_readdata  out  DATA_W  processor read data
- p_stall  out  1  processor request not yet complete
- h_req  in  1  host request (level, held until h_gnt)
- h_we  in  1  host write(1)/read(0)
- h_address  in  ADDR_W  host address
- h_byteena  in  BE_W  host byte enables
- h_writedata  in  DATA_W  host write data
- h_gnt  out  1  host request issued this cycle
- h_rvalid  out  1  host read data valid (1-cycle pulse)
- h_readdata  out  DATA_W  host read data
- ram_address  out  ADDR_W  RAM address
- ram_byteena  out  BE_W  RAM byte enables
- ram_data  out  DATA_W  RAM write data
- ram_rden  out  1  RAM read enable
- ram_wren  out  1  RAM write enable
- ram_q  in  DATA_W  RAM read data, valid RD_LAT cycles after issue

Behaviour:
- Reset: all outputs 0, state IDLE, wait counter 0. An in-flight read is discarded with no return pulse. Reset asserted mid-operation behaves the same.
- Request definitions: p_req = p_rden | p_wren. If both are high the request is a write.
- States:
  - IDLE: issues at most one RAM access per cycle.
  - P_RD: waiting on a processor read.
  - H_RD: waiting on a host read.
- Arbitration in IDLE:
  - Host wins if h_req and (wcnt==MAX_WAIT or !p_req).
  - Otherwise the processor wins if p_req.
  - A simultaneous request with wcnt<MAX_WAIT goes to the processor.
- Wait counter: wcnt increments when h_req is high and the host is not granted, saturates at MAX_WAIT, and clears on h_gnt.
- Issue cycle: ram_* is driven combinationally from the winner's inputs, with exactly one of ram_rden/ram_wren high.
  - Write: completes in the issue cycle and the state stays IDLE. For the processor, p_stall=0 that cycle. For the host, h_gnt=1.
  - Read: latency counter loads RD_LAT-1 and the state goes to P_RD or H_RD. For a processor read, p_stall=1. For a host read, h_gnt=1.
- P_RD/H_RD:
  - No RAM issue; ram_rden=ram_wren=0.
  - Counter decrements each cycle. When it reaches 0 (the RD_LAT-th cycle after issue), ram_q is valid.
  - P_RD completion: p_readdata=ram_q, registered and held until the next processor read completes. p_stall=0 in this cycle. Next state is IDLE.
  - H_RD completion: h_readdata=ram_q (held), h_rvalid=1 for one cycle. Next state is IDLE.
- p_stall = p_req & !(processor write issued this cycle | processor read completing this cycle).
  - The processor request is consumed in its completion cycle and is never re-issued.
  - A processor request that is still held the next cycle is treated as a new request.
- Exactly one outstanding transaction at a time; no pipelined reads.
- RAM outputs are 0 when not issuing.

Decomposition:
- Package vmem_arbiter_pkg:
  - state enum {IDLE, P_RD, H_RD}
  - owner enum {OWN_P, OWN_H}
  - width localparams derived from the defaults
- Sub-module arb_wait_counter: saturating host-starvation counter with inc/clr/sat outputs, instantiated once.
- Latency counter and FSM live in the top module.

Test Plan:
- Processor write: p_wren=1, addr 0x0010, be=all-ones → ram_wren=1 in the same cycle, p_stall=0, next cycle IDLE.
- Processor read, RD_LAT=2: p_rden at cycle 0, ram_q=0xA5.. at cycle 2 → p_stall=1 at cycles 0–1 and 0 at cycle 2. p_readdata=0xA5.. from cycle 2 and holds afterwards. Exactly one ram_rden pulse, at cycle 0.
- Host read while processor idle: h_req/h_we=0, addr 0x3FFF → h_gnt at cycle 0, h_rvalid one-cycle pulse at cycle 2 with h_readdata=ram_q.
- Starvation: p_wren held high for 10 back-to-back writes plus a continuous host write request.
  - Processor is issued cycles 0–3 and wcnt saturates at 4.
  - Host is granted at cycle 4 with p_stall=1 that cycle.
  - Processor resumes at cycle 5.
- Simultaneous p_rden and h_req at wcnt=0 → processor issued first. h_gnt arrives the cycle after the processor read completes (cycle 3).
- Reset pulsed low during H_RD → all outputs 0 immediately, no h_rvalid. After release, the state is IDLE and a new processor read proceeds normally.
